// File: rtl/ls_pkg.sv
// Shared definitions for the LS-series shift-register models.
// Stage index 0 is QA (serial input end), index LS165_STAGES-1 is QH.
package ls_pkg;

  localparam int unsigned LS165_STAGES = 8;

  // Positions of the device pins inside the packed synchroniser vector.
  localparam int unsigned LS165_PIN_PAR_LO = 0;  // _A.._H occupy 0..7
  localparam int unsigned LS165_PIN_SH_LD  = 8;
  localparam int unsigned LS165_PIN_CLK    = 9;
  localparam int unsigned LS165_PIN_INH    = 10;
  localparam int unsigned LS165_PIN_SER    = 11;
  localparam int unsigned LS165_NUM_PINS   = 12;

  typedef logic [LS165_STAGES-1:0] ls_stage_t;

  // Register action selected for one system cycle.
  typedef enum logic [1:0] {
    LS_OP_HOLD  = 2'd0,
    LS_OP_LOAD  = 2'd1,
    LS_OP_SHIFT = 2'd2
  } ls_op_t;

  // Move every stage one place towards QH and bring ser into QA.
  function automatic ls_stage_t ls_shift_up(input ls_stage_t s, input logic ser);
    return {s[LS165_STAGES-2:0], ser};
  endfunction

endpackage

// File: rtl/ls_pin_sync.sv
// Per-pin synchroniser into the system clock domain.
// SYNC_STAGES = 0 passes the pin straight through; RST_VAL is the
// value every flop takes while RST is high.
module ls_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      logic w_unused_bypass;
      assign w_unused_bypass = CLK & RST;
      assign o_q             = i_d;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift chain: pin enters flop 0, output taken from the last flop.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
          r_sync[0] <= i_d;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign o_q = r_sync[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ls165_pisos.sv
// SN74LS165 8-bit parallel-load / serial-out shift register, cycle model.
// Device pins are synchronised to CLK; the shift clock is (CLK pin OR
// CLK INH pin) and shifts on its rising edge as seen at the system clock.
// Load (_SH_LD low) is level-sensitive and overrides shifting.
module ls165_pisos
  import ls_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2  // legal 0..3
) (
  input  logic CLK,
  input  logic RST,
  input  logic _SH_LD,
  input  logic _CLK,
  input  logic _CLK_INH,
  input  logic _SER,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  input  logic _E,
  input  logic _F,
  input  logic _G,
  input  logic _H,
  output logic _QH,
  output logic _QH_N
);

  logic [LS165_NUM_PINS-1:0] w_pin_raw;
  logic [LS165_NUM_PINS-1:0] w_pin_s;
  ls_stage_t                 w_par;
  logic                      w_sld;
  logic                      w_clk_s;
  logic                      w_inh_s;
  logic                      w_ser;
  logic                      w_gclk;
  logic                      w_rise;
  ls_op_t                    w_op;
  ls_stage_t                 w_stages_nxt;
  logic                      r_gclk_prev;
  ls_stage_t                 r_stages;

  assign w_pin_raw = {_SER, _CLK_INH, _CLK, _SH_LD, _H, _G, _F, _E, _D, _C, _B, _A};

  // The inhibit synchroniser resets high so the gated clock is already
  // high at reset release and no edge can be fabricated from reset.
  generate
    for (genvar gi = 0; gi < LS165_NUM_PINS; gi++) begin : g_pin
      ls_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     ((gi == LS165_PIN_INH) ? 1'b1 : 1'b0)
      ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .i_d (w_pin_raw[gi]),
        .o_q (w_pin_s[gi])
      );
    end
  endgenerate

  assign w_par   = w_pin_s[LS165_PIN_PAR_LO +: LS165_STAGES];
  assign w_sld   = w_pin_s[LS165_PIN_SH_LD];
  assign w_clk_s = w_pin_s[LS165_PIN_CLK];
  assign w_inh_s = w_pin_s[LS165_PIN_INH];
  assign w_ser   = w_pin_s[LS165_PIN_SER];

  assign w_gclk = w_clk_s | w_inh_s;
  assign w_rise = w_gclk & ~r_gclk_prev;

  // Gated-clock history; resets high so the first cycle cannot see a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gclk_prev <= 1'b1;
    end else begin
      r_gclk_prev <= w_gclk;
    end
  end

  // Select the action: load beats shift, shift needs a gated-clock rise.
  always_comb begin
    w_op = LS_OP_HOLD;
    if (!w_sld) begin
      w_op = LS_OP_LOAD;
    end else if (w_rise) begin
      w_op = LS_OP_SHIFT;
    end
  end

  // Next register contents for the selected action.
  always_comb begin
    w_stages_nxt = r_stages;
    unique case (w_op)
      LS_OP_LOAD:  w_stages_nxt = w_par;
      LS_OP_SHIFT: w_stages_nxt = ls_shift_up(r_stages, w_ser);
      default:     w_stages_nxt = r_stages;
    endcase
  end

  // The eight register stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stages <= '0;
    end else begin
      r_stages <= w_stages_nxt;
    end
  end

  assign _QH   = r_stages[LS165_STAGES-1];
  assign _QH_N = ~r_stages[LS165_STAGES-1];

endmodule

// File: tb/tb_ls165_pisos.sv
// Scoreboard bench for ls165_pisos: one instance with SYNC_STAGES = 2 and
// one with SYNC_STAGES = 0 share all pins. Stimulus pushes expected QH
// values tagged with the system cycle they must appear in; the monitor
// pops and compares them on the falling clock edge (or on a probe strobe
// for the asynchronous reset check, tag -1).
`timescale 1ns/1ps
module tb_ls165_pisos;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin_sh_ld, pin_clk, pin_inh, pin_ser;
  logic [7:0] par;
  logic       qh2, qhn2, qh0, qhn0;
  logic       probe = 1'b0;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int    cyc;
    int    sel;
    logic  exp;
    string nm;
  } exp_t;

  exp_t sb[$];
  logic exp1 [0:8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ls165_pisos #(.SYNC_STAGES(2)) dut2 (
    .CLK(clk), .RST(rst), ._SH_LD(pin_sh_ld), ._CLK(pin_clk), ._CLK_INH(pin_inh),
    ._SER(pin_ser), ._A(par[0]), ._B(par[1]), ._C(par[2]), ._D(par[3]),
    ._E(par[4]), ._F(par[5]), ._G(par[6]), ._H(par[7]), ._QH(qh2), ._QH_N(qhn2)
  );

  ls165_pisos #(.SYNC_STAGES(0)) dut0 (
    .CLK(clk), .RST(rst), ._SH_LD(pin_sh_ld), ._CLK(pin_clk), ._CLK_INH(pin_inh),
    ._SER(pin_ser), ._A(par[0]), ._B(par[1]), ._C(par[2]), ._D(par[3]),
    ._E(par[4]), ._F(par[5]), ._G(par[6]), ._H(par[7]), ._QH(qh0), ._QH_N(qhn0)
  );

  task automatic push(input int sel, input string nm, input logic e, input int at);
    exp_t x;
    x.cyc = at; x.sel = sel; x.exp = e; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic check(input exp_t x);
    logic [1:0] act, req;
    act = (x.sel == 0) ? {qh0, qhn0} : {qh2, qhn2};
    req = {x.exp, ~x.exp};
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (dut sync=%0d, cycle %0d): {QH,QH_N} = %b, expected %b",
               x.nm, x.sel, cyc, act, req);
    end
  endtask

  // Monitor: compare every expectation whose cycle tag has arrived.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or posedge probe);
      while (sb.size() > 0 && (sb[0].cyc < 0 || sb[0].cyc <= cyc)) begin
        x = sb.pop_front();
        if (x.cyc >= 0 && x.cyc < cyc) begin
          n_run++;
          n_fail++;
          $display("FAIL %s: slot cycle %0d missed, now cycle %0d", x.nm, x.cyc, cyc);
        end else begin
          check(x);
        end
      end
    end
  end

  // One _CLK pulse on the pin; with two sync stages the shift shows 3 cycles later.
  task automatic pulse(input logic eb, input logic ea, input string nm);
    @(negedge clk);
    pin_clk = 1'b1;
    push(2, {nm, "_pre"}, eb, cyc + 2);
    push(2, nm, ea, cyc + 3);
    repeat (4) @(negedge clk);
    pin_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] v, input logic eb, input logic ea, input string nm);
    @(negedge clk);
    par       = v;
    pin_sh_ld = 1'b0;
    push(2, {nm, "_pre"}, eb, cyc + 2);
    push(2, nm, ea, cyc + 3);
    repeat (4) @(negedge clk);
    pin_sh_ld = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 8'b1011_0010 shifted out with _SER = 0: after load, then after each rise.
    exp1[0] = 1'b1; exp1[1] = 1'b0; exp1[2] = 1'b1; exp1[3] = 1'b1; exp1[4] = 1'b0;
    exp1[5] = 1'b0; exp1[6] = 1'b1; exp1[7] = 1'b0; exp1[8] = 1'b0;

    rst = 1'b1; pin_sh_ld = 1'b1; pin_clk = 1'b0; pin_inh = 1'b0; pin_ser = 1'b0; par = 8'h00;
    push(2, "rst_init", 1'b0, 2);
    push(0, "rst_init_s0", 1'b0, 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Load and shift out
    load_byte(8'b1011_0010, 1'b0, exp1[0], "ld_B2");
    for (int i = 1; i <= 8; i++) pulse(exp1[i-1], exp1[i], $sformatf("shout%0d", i));
    pulse(1'b0, 1'b0, "shout9");

    // Clock inhibit
    load_byte(8'h55, 1'b0, 1'b0, "ld_55");
    @(negedge clk);
    pin_clk = 1'b1;
    push(2, "inh_setup_pre", 1'b0, cyc + 2);
    push(2, "inh_setup", 1'b1, cyc + 3);
    repeat (4) @(negedge clk);
    pin_inh = 1'b1;
    repeat (4) @(negedge clk);
    pin_clk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 4; i++) pulse(1'b1, 1'b1, $sformatf("inh_blk%0d", i));
    @(negedge clk);
    pin_clk = 1'b1;
    repeat (4) @(negedge clk);
    pin_inh = 1'b0;
    push(2, "inh_drop_hi", 1'b1, cyc + 3);
    push(2, "inh_drop_hi_late", 1'b1, cyc + 6);
    repeat (8) @(negedge clk);
    pin_clk = 1'b0;
    repeat (4) @(negedge clk);
    pin_inh = 1'b1;
    push(2, "inh_rise_lo_pre", 1'b1, cyc + 2);
    push(2, "inh_rise_lo", 1'b0, cyc + 3);
    push(2, "inh_rise_lo_once", 1'b0, cyc + 6);
    repeat (8) @(negedge clk);
    pin_inh = 1'b0;
    repeat (4) @(negedge clk);

    // Serial chaining
    load_byte(8'h00, 1'b0, 1'b0, "ld_00");
    @(negedge clk);
    pin_ser = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 7; i++) pulse(1'b0, 1'b0, $sformatf("chain%0d", i));
    pulse(1'b0, 1'b1, "chain8");
    for (int i = 9; i <= 12; i++) pulse(1'b1, 1'b1, $sformatf("chain%0d", i));

    // Load overrides shifting
    @(negedge clk);
    pin_ser = 1'b0; par = 8'h55; pin_sh_ld = 1'b0;
    push(2, "ovr_ld55_pre", 1'b1, cyc + 2);
    push(2, "ovr_ld55", 1'b0, cyc + 3);
    repeat (4) @(negedge clk);
    pulse(1'b0, 1'b0, "ovr_a1");
    pulse(1'b0, 1'b0, "ovr_a2");
    @(negedge clk);
    par = 8'hAA;
    push(2, "ovr_ldAA_pre", 1'b0, cyc + 2);
    push(2, "ovr_ldAA", 1'b1, cyc + 3);
    repeat (4) @(negedge clk);
    for (int i = 3; i <= 5; i++) pulse(1'b1, 1'b1, $sformatf("ovr_a%0d", i));
    @(negedge clk);
    pin_sh_ld = 1'b1;
    repeat (4) @(negedge clk);
    pulse(1'b1, 1'b0, "ovr_out1");
    pulse(1'b0, 1'b1, "ovr_out2");
    pulse(1'b1, 1'b0, "ovr_out3");

    // Asynchronous reset mid-operation, then no spurious shift on release
    load_byte(8'hFF, 1'b0, 1'b1, "ld_FF");
    @(negedge clk);
    pin_clk = 1'b1; pin_ser = 1'b1; rst = 1'b1;
    #1;
    push(2, "rst_async", 1'b0, -1);
    push(0, "rst_async_s0", 1'b0, -1);
    push(2, "rst_hold", 1'b0, cyc + 1);
    probe = 1'b1;
    #1 probe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    pin_clk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 7; i++) pulse(1'b0, 1'b0, $sformatf("post_rst%0d", i));
    pulse(1'b0, 1'b1, "post_rst8");

    // SYNC_STAGES = 0 latency
    @(negedge clk);
    pin_ser = 1'b0; par = 8'h00; pin_sh_ld = 1'b0;
    repeat (4) @(negedge clk);
    push(0, "s0_zero", 1'b0, cyc + 1);
    @(negedge clk);
    par = 8'h80;
    push(0, "s0_ld80", 1'b1, cyc + 1);
    push(2, "s2_ld80_pre", 1'b0, cyc + 2);
    push(2, "s2_ld80", 1'b1, cyc + 3);
    repeat (4) @(negedge clk);
    pin_sh_ld = 1'b1;
    repeat (4) @(negedge clk);
    push(0, "s0_pre_rise", 1'b1, cyc + 1);
    @(negedge clk);
    pin_clk = 1'b1;
    push(0, "s0_shift", 1'b0, cyc + 1);
    push(2, "s2_shift_pre", 1'b1, cyc + 2);
    push(2, "s2_shift", 1'b0, cyc + 3);
    repeat (4) @(negedge clk);
    pin_clk = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", x.nm, x.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
